// File: rtl/mult_req_pkg.sv
// rtl/mult_req_pkg.sv - Shared state encoding and default widths for the Multiplicator requester.
package mult_req_pkg;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_COUNT_W        = 16;
  localparam int DEF_TIMEOUT_CYCLES = 48;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/mult_req_timer.sv
// rtl/mult_req_timer.sv - Loadable/clearable down-counter with expired flag (MULT_REQ_TIMEOUT_EN watchdog).
module mult_req_timer #(
  parameter int LIMIT = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // Loading LIMIT-1 makes expired rise during the LIMIT-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (load) begin
      cnt_d = CW'(LIMIT - 1);
      run_d = 1'b1;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/mult_requester.sv
// rtl/mult_requester.sv - Multiplicator initiator: host operand/result streams, one multiply in flight.
// Define MULT_REQ_TIMEOUT_EN to add the issue/wait watchdog that drives oRes_Error.
module mult_requester
  import mult_req_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int COUNT_W        = DEF_COUNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iOp_Valid,
  output logic                        oOp_Ready,
  input  logic [DATA_W-1:0]           iOp_A,
  input  logic [DATA_W-1:0]           iOp_B,
  output logic                        oRes_Valid,
  input  logic                        iRes_Ready,
  output logic [prod_w(DATA_W)-1:0]   oRes_Data,
  output logic                        oRes_Error,
  output logic [DATA_W-1:0]           oData_A,
  output logic [DATA_W-1:0]           oData_B,
  output logic                        oValid_Data,
  input  logic                        iIdle,
  input  logic                        iDone,
  input  logic [prod_w(DATA_W)-1:0]   iResult,
  output logic                        oAcknowledged,
  output logic [COUNT_W-1:0]          oOp_Count
);

  localparam int PW = prod_w(DATA_W);

  state_t              state_q, state_d;
  logic                op_ready_q, op_ready_d;
  logic                valid_data_q, valid_data_d;
  logic                ack_q, ack_d;
  logic                res_valid_q, res_valid_d;
  logic                res_error_q, res_error_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic [PW-1:0]       res_data_q, res_data_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic op_take, res_take, done_take, timeout, to_hit;

  assign op_take   = (state_q == S_IDLE) && iOp_Valid && op_ready_q;
  assign res_take  = (state_q == S_OUT) && iRes_Ready;
  assign done_take = (state_q == S_WAIT) && iDone;

`ifdef MULT_REQ_TIMEOUT_EN
  logic expired;

  mult_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (res_take),
    .load    (op_take),
    .en      ((state_q == S_ISSUE) || (state_q == S_WAIT)),
    .expired (expired)
  );

  assign timeout = expired && ((state_q == S_ISSUE) || (state_q == S_WAIT));
`else
  assign timeout = 1'b0;
`endif

  // A result arriving on the same cycle as the watchdog wins.
  assign to_hit = timeout && !done_take;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_take) state_d = S_ISSUE;
      S_ISSUE: if (to_hit) state_d = S_OUT; else if (iIdle) state_d = S_WAIT;
      S_WAIT:  if (done_take) state_d = S_ACK; else if (to_hit) state_d = S_OUT;
      S_ACK:   state_d = S_OUT;
      S_OUT:   if (res_take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flag outputs follow the next state so every output comes straight from a flop.
  always_comb begin
    op_ready_d   = (state_d == S_IDLE);
    valid_data_d = (state_d == S_ISSUE);
    ack_d        = (state_d == S_ACK);
    res_valid_d  = (state_d == S_OUT);
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    res_data_d   = res_data_q;
    res_error_d  = res_error_q;
    count_d      = count_q;
    if (op_take) begin
      data_a_d = iOp_A;
      data_b_d = iOp_B;
    end
    if (done_take) res_data_d = iResult;
    if (to_hit) begin
      res_data_d  = '0;
      res_error_d = 1'b1;
    end
    if (res_take) begin
      res_error_d = 1'b0;
      count_d     = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      op_ready_q   <= 1'b0;
      valid_data_q <= 1'b0;
      ack_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_error_q  <= 1'b0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      res_data_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_ready_q   <= op_ready_d;
      valid_data_q <= valid_data_d;
      ack_q        <= ack_d;
      res_valid_q  <= res_valid_d;
      res_error_q  <= res_error_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      res_data_q   <= res_data_d;
      count_q      <= count_d;
    end
  end

  assign oOp_Ready     = op_ready_q;
  assign oValid_Data   = valid_data_q;
  assign oAcknowledged = ack_q;
  assign oRes_Valid    = res_valid_q;
  assign oRes_Error    = res_error_q;
  assign oData_A       = data_a_q;
  assign oData_B       = data_b_q;
  assign oRes_Data     = res_data_q;
  assign oOp_Count     = count_q;

endmodule

// File: tb/tb_mult_requester.sv
// tb/tb_mult_requester.sv - Scoreboard bench for mult_requester with a behavioural 32-cycle multiplier.
// Covers the MULT_REQ_TIMEOUT_EN watchdog when the macro is defined, otherwise the indefinite wait.
module tb_mult_requester;

  localparam int TB_COUNT_W = 4;

  logic        Clock;
  logic        Reset;
  logic        iOp_Valid;
  logic        oOp_Ready;
  logic [31:0] iOp_A, iOp_B;
  logic        oRes_Valid;
  logic        iRes_Ready;
  logic [63:0] oRes_Data;
  logic        oRes_Error;
  logic [31:0] oData_A, oData_B;
  logic        oValid_Data;
  logic        iIdle;
  logic        iDone;
  logic [63:0] iResult;
  logic        oAcknowledged;
  logic [TB_COUNT_W-1:0] oOp_Count;

  mult_requester #(.COUNT_W(TB_COUNT_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .iOp_Valid(iOp_Valid), .oOp_Ready(oOp_Ready), .iOp_A(iOp_A), .iOp_B(iOp_B),
    .oRes_Valid(oRes_Valid), .iRes_Ready(iRes_Ready), .oRes_Data(oRes_Data), .oRes_Error(oRes_Error),
    .oData_A(oData_A), .oData_B(oData_B), .oValid_Data(oValid_Data),
    .iIdle(iIdle), .iDone(iDone), .iResult(iResult),
    .oAcknowledged(oAcknowledged), .oOp_Count(oOp_Count)
  );

  typedef struct {
    logic [63:0] prod;
    bit          err;
    bit          lat;
    int          exp_lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_count = 0;
  int idle_block = 0;
  bit no_done = 0;
  bit rand_ready = 0;
  bit rres = 1;
  logic [31:0] last_a = 0, last_b = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  always @(negedge Clock) iRes_Ready = rand_ready ? ($urandom_range(0, 3) != 0) : rres;

  // Behavioural multiplier: takes a request when idle, answers 32 cycles later, holds done until ack.
  bit          m_pv = 0, m_busy = 0;
  int          m_cnt = 0;
  logic [63:0] m_prod = 0;
  initial begin
    iIdle = 1'b1;
    iDone = 1'b0;
    iResult = '0;
  end
  always begin
    @(posedge Clock);
    #1;
    if (Reset) begin
      m_busy = 0; m_cnt = 0; m_pv = 0; idle_block = 0;
      iDone = 1'b0; iIdle = 1'b1;
    end else begin
      if (m_pv && iIdle) begin
        m_busy = 1; m_cnt = 32; iIdle = 1'b0;
        m_prod = 64'(oData_A) * 64'(oData_B);
      end else if (m_busy && !iDone) begin
        if (m_cnt > 0) m_cnt--;
        if (m_cnt == 0 && !no_done) begin
          iDone = 1'b1;
          iResult = m_prod;
        end
      end else if (iDone && oAcknowledged) begin
        iDone = 1'b0;
        m_busy = 0;
      end
      if (!m_busy) begin
        if (idle_block > 0) idle_block--;
        iIdle = (idle_block == 0);
      end
      m_pv = oValid_Data;
    end
  end

  // Monitor: pops the scoreboard on each result handshake and watches protocol invariants.
  bit          mon_pv = 0, mon_pe = 0;
  logic [63:0] mon_pd = 0;
  int          ack_run = 0;
  always begin
    exp_t e;
    @(posedge Clock);
    #1;
    if (Reset) begin
      sb.delete();
      exp_count = 0; mon_pv = 0; ack_run = 0;
    end else begin
      if (mon_pv && iRes_Ready) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_result");
        end else begin
          e = sb.pop_front();
          check("res_data", mon_pd, e.prod);
          check("res_error", 64'(mon_pe), 64'(e.err));
        end
        exp_count = (exp_count + 1) % (1 << TB_COUNT_W);
        check("op_count", 64'(oOp_Count), 64'(exp_count));
        check("valid_drop", 64'(oRes_Valid), 64'd0);
      end else if (mon_pv) begin
        check("stall_valid", 64'(oRes_Valid), 64'd1);
        check("stall_data", oRes_Data, mon_pd);
      end
      if (oRes_Valid && !mon_pv && sb.size() > 0 && sb[0].lat)
        check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].exp_lat));
      if (oRes_Valid) check("ready_in_out", 64'(oOp_Ready), 64'd0);
      if (oValid_Data) begin
        check("issue_a", 64'(oData_A), 64'(last_a));
        check("issue_b", 64'(oData_B), 64'(last_b));
        check("ready_in_issue", 64'(oOp_Ready), 64'd0);
      end
      if (oAcknowledged) ack_run++;
      else if (ack_run > 0) begin
        check("ack_width", 64'(ack_run), 64'd1);
        ack_run = 0;
      end
      mon_pv = oRes_Valid; mon_pd = oRes_Data; mon_pe = oRes_Error;
    end
  end

  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                          input bit lat, input logic [63:0] ep, input bit ee);
    int n = 0;
    iOp_A = a; iOp_B = b; iOp_Valid = 1'b1;
    while (!oOp_Ready && n < 400) begin
      @(negedge Clock);
      n++;
    end
    if (!oOp_Ready) bound_fail("accept");
    if (push) sb.push_back('{prod: ep, err: ee, lat: lat, exp_lat: ee ? 48 : 35, acc: cyc + 1});
    last_a = a; last_b = b;
    @(negedge Clock);
    iOp_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && oOp_Ready) && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 2000) bound_fail("wait_idle");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(oOp_Ready), 64'd0);
    check({tag, "_vdata"}, 64'(oValid_Data), 64'd0);
    check({tag, "_rvalid"}, 64'(oRes_Valid), 64'd0);
    check({tag, "_rdata"}, oRes_Data, 64'd0);
    check({tag, "_rerr"}, 64'(oRes_Error), 64'd0);
    check({tag, "_a"}, 64'(oData_A), 64'd0);
    check({tag, "_b"}, 64'(oData_B), 64'd0);
    check({tag, "_ack"}, 64'(oAcknowledged), 64'd0);
    check({tag, "_count"}, 64'(oOp_Count), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int vcnt, rdy_seen, vlost, ib, n;
    Reset = 1'b1; iOp_Valid = 1'b0; iOp_A = '0; iOp_B = '0;
    repeat (3) @(negedge Clock);
    check_zero("reset");
    Reset = 1'b0;
    @(negedge Clock);
    check("ready_after_reset", 64'(oOp_Ready), 64'd1);

    issue_op(32'd7, 32'd6, 1, 1, 64'd42, 0);
    wait_idle();
    check("count_after_first", 64'(oOp_Count), 64'd1);

    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 64'hFFFF_FFFE_0000_0001, 0);
    wait_idle();

    idle_block = 11;
    issue_op(32'h1234_5678, 32'h9ABC_DEF0, 1, 0, prod(32'h1234_5678, 32'h9ABC_DEF0), 0);
    vcnt = 0;
    while (oValid_Data && vcnt < 100) begin
      vcnt++;
      @(negedge Clock);
    end
    check("issue_hold_ge10", 64'(vcnt >= 10), 64'd1);
    wait_idle();

    rres = 0;
    issue_op(32'd1000, 32'd3000, 1, 1, 64'd3000000, 0);
    n = 0;
    while (!oRes_Valid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (!oRes_Valid) bound_fail("bp_valid");
    a = 32'hDEAD_BEEF; b = 32'h0000_0010;
    iOp_A = a; iOp_B = b; iOp_Valid = 1'b1;
    rdy_seen = 0; vlost = 0;
    repeat (20) begin
      @(negedge Clock);
      if (oOp_Ready) rdy_seen++;
      if (!oRes_Valid) vlost++;
    end
    check("bp_ready_low", 64'(rdy_seen), 64'd0);
    check("bp_valid_held", 64'(vlost), 64'd0);
    rres = 1;
    issue_op(a, b, 1, 1, prod(a, b), 0);
    wait_idle();

    issue_op(32'd55, 32'd66, 1, 1, 64'd3630, 0);
    repeat (15) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_zero("mid_reset");
    check("mid_reset_sb", 64'(sb.size()), 64'd0);
    issue_op(32'd123, 32'd456, 1, 1, 64'd56088, 0);
    wait_idle();
    check("count_after_reset", 64'(oOp_Count), 64'd1);

    rand_ready = 1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      ib = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      idle_block = ib;
      issue_op(a, b, 1, ib == 0, prod(a, b), 0);
      wait_idle();
    end
    rand_ready = 0;
    repeat (2) @(negedge Clock);

    no_done = 1;
`ifdef MULT_REQ_TIMEOUT_EN
    issue_op(32'd9, 32'd9, 1, 1, 64'd0, 1);
    wait_idle();
`else
    issue_op(32'd9, 32'd9, 0, 0, 64'd0, 0);
    repeat (100) @(negedge Clock);
    check("nodone_rvalid", 64'(oRes_Valid), 64'd0);
    check("nodone_vdata", 64'(oValid_Data), 64'd0);
    check("nodone_ready", 64'(oOp_Ready), 64'd0);
`endif
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    no_done = 0;
    @(negedge Clock);
    check("final_ready", 64'(oOp_Ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
